reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter W_RD, default 4, register-name width; NREG = 2**W_RD registers tracked.
REQ-002 SHALL have parameter CNT_W, default 2, per-register pending-write counter width; MAX = 2**CNT_W-1.
REQ-003 SHALL have one clock and an asynchronous active-low reset.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 rd_name_i  in  W_RD  lookup port A register name (decode rd).
REQ-007 rs_name_i  in  W_RD  lookup port B register name (decode rs).
REQ-008 rd_reserved_o  out  1  register rd_name_i has >=1 pending write.
REQ-009 rs_reserved_o  out  1  register rs_name_i has >=1 pending write.
REQ-010 reserve_i  in  1  request to add one pending write.
REQ-011 reserve_name_i  in  W_RD  register to reserve.
REQ-012 reserve_ack_o  out  1  reservation accepted this cycle.
REQ-013 release_i  in  1  writeback retiring one pending write.
REQ-014 release_name_i  in  W_RD  register being written back.
REQ-015 flush_i  in  1  discard all pending reservations.
REQ-016 pending_o  out  NREG  bit n = counter n nonzero.
REQ-017 err_o  out  1  sticky underflow error flag.

Function
REQ-018 SHALL hold one CNT_W-bit counter cnt[n] per register n.
REQ-019 rd_reserved_o / rs_reserved_o SHALL be combinational (cnt[name] != 0) from registered state only; no same-cycle release bypass.
REQ-020 pending_o[n] SHALL equal (cnt[n] != 0) from registered state.
REQ-021 reserve_ack_o SHALL be combinational: reserve_i & ~flush_i & (cnt[reserve_name_i] != MAX | (release_i & release_name_i == reserve_name_i)).
REQ-022 Accepted reserve alone SHALL increment cnt[reserve_name_i] by 1 at the next edge.
REQ-023 Refused reserve (counter at MAX, no matching release) SHALL leave counters unchanged; requester must hold and retry.
REQ-024 release_i with cnt[release_name_i] != 0 SHALL decrement that counter by 1 at the next edge.
REQ-025 Accepted reserve and release to the same register in one cycle SHALL leave that counter unchanged.
REQ-026 Accepted reserve and release to different registers in one cycle SHALL apply both updates.
REQ-027 release_i with cnt[release_name_i] == 0 (and no same-register accepted reserve) SHALL leave counter at 0 and set err_o at the next edge.
REQ-028 Release to a counter at 0 with same-register accepted reserve the same cycle SHALL leave counter at 0 and not set err_o.
REQ-029 err_o SHALL remain 1 until reset; flush_i does not clear it.
REQ-030 flush_i SHALL clear all counters to 0 at the next edge, overriding reserve_i and release_i that cycle; release during flush SHALL NOT set err_o.
REQ-031 Counters SHALL never wrap: no increment past MAX, no decrement below 0.
REQ-032 Latency: any update SHALL be visible on lookup outputs exactly one cycle after the causing edge.

Reset
REQ-033 While rst=0 all counters SHALL be 0 and err_o 0, so rd_reserved_o, rs_reserved_o and pending_o are 0 regardless of clk.
REQ-034 Reset asserted mid-operation SHALL discard all pending reservations immediately; first edge after release of reset SHALL process inputs normally.

Verification
REQ-035 Reset then reserve r3 one cycle -> reserve_ack_o=1; next cycle rd_name_i=3 gives rd_reserved_o=1, pending_o=16'h0008.
REQ-036 Reserve r5 three cycles (MAX=3), then a fourth -> fourth reserve_ack_o=0, cnt[5] stays 3; three releases of r5 -> pending_o[5]=0 after the third.
REQ-037 cnt[2]=3, reserve r2 and release r2 same cycle -> reserve_ack_o=1, cnt[2] stays 3, err_o=0.
REQ-038 Release r7 with cnt[7]=0 -> err_o=1 next cycle, cnt[7]=0; err_o still 1 after a flush, 0 only after rst=0.
REQ-039 cnt[1]=2, cnt[4]=1; flush_i with reserve r1 and release r4 same cycle -> reserve_ack_o=0, next cycle pending_o=0, err_o=0.
REQ-040 cnt[6]=2, assert rst=0 between edges -> rs_reserved_o for rs_name_i=6 drops to 0 without a clock edge.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register reservation scoreboard: one saturating pending-write counter per
// architectural register, with two lookup ports, reserve/release and flush.
module reg_scoreboard #(
  parameter int W_RD  = 4,
  parameter int CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W_RD-1:0]      rd_name_i,
  input  logic [W_RD-1:0]      rs_name_i,
  output logic                 rd_reserved_o,
  output logic                 rs_reserved_o,
  input  logic                 reserve_i,
  input  logic [W_RD-1:0]      reserve_name_i,
  output logic                 reserve_ack_o,
  input  logic                 release_i,
  input  logic [W_RD-1:0]      release_name_i,
  input  logic                 flush_i,
  output logic [(2**W_RD)-1:0] pending_o,
  output logic                 err_o
);

  localparam int NREG = 2**W_RD;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NREG-1:0][CNT_W-1:0] cnt_r;
  logic [NREG-1:0][CNT_W-1:0] cnt_nxt_s;
  logic                       err_r;
  logic                       same_s;
  logic                       ack_s;
  logic                       rel_s;
  logic                       underflow_s;
  logic [NREG-1:0]            inc_s;
  logic [NREG-1:0]            dec_s;

  // Accept/refuse a reservation; a matching release frees a slot in a full counter.
  always_comb begin
    same_s      = release_i && (release_name_i == reserve_name_i);
    ack_s       = reserve_i && !flush_i && ((cnt_r[reserve_name_i] != CNT_MAX) || same_s);
    rel_s       = release_i && !flush_i;
    underflow_s = rel_s && (cnt_r[release_name_i] == CNT_ZERO) && !(ack_s && same_s);
  end

  // Per-register increment/decrement strobes; a same-register reserve cancels the release.
  always_comb begin
    inc_s = '0;
    dec_s = '0;
    for (int n = 0; n < NREG; n++) begin
      inc_s[n] = ack_s && (reserve_name_i == W_RD'(n));
      dec_s[n] = rel_s && (release_name_i == W_RD'(n)) &&
                 ((cnt_r[n] != CNT_ZERO) || inc_s[n]);
    end
  end

  // Next counter values; flush wins over everything else.
  always_comb begin
    cnt_nxt_s = cnt_r;
    for (int n = 0; n < NREG; n++) begin
      if (flush_i) begin
        cnt_nxt_s[n] = CNT_ZERO;
      end else if (inc_s[n] && !dec_s[n]) begin
        cnt_nxt_s[n] = cnt_r[n] + CNT_ONE;
      end else if (dec_s[n] && !inc_s[n]) begin
        cnt_nxt_s[n] = cnt_r[n] - CNT_ONE;
      end else begin
        cnt_nxt_s[n] = cnt_r[n];
      end
    end
  end

  // Counter and sticky error state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
      err_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      err_r <= err_r || underflow_s;
    end
  end

  // Lookup outputs straight from registered state, no release bypass.
  always_comb begin
    pending_o = '0;
    for (int n = 0; n < NREG; n++) begin
      pending_o[n] = (cnt_r[n] != CNT_ZERO);
    end
    rd_reserved_o = (cnt_r[rd_name_i] != CNT_ZERO);
    rs_reserved_o = (cnt_r[rs_name_i] != CNT_ZERO);
    reserve_ack_o = ack_s;
    err_o         = err_r;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: stimulus queues expected lookups,
// a negedge monitor pops and compares them against the DUT.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic [3:0]  rd_name_i;
  logic [3:0]  rs_name_i;
  logic        rd_reserved_o;
  logic        rs_reserved_o;
  logic        reserve_i;
  logic [3:0]  reserve_name_i;
  logic        reserve_ack_o;
  logic        release_i;
  logic [3:0]  release_name_i;
  logic        flush_i;
  logic [15:0] pending_o;
  logic        err_o;

  typedef struct packed {
    logic [7:0]  id;
    logic [4:0]  m;   // ack, rd, rs, err, pend
    logic        a;
    logic        r;
    logic        s;
    logic        e;
    logic [15:0] p;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;

  reg_scoreboard #(.W_RD(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .rd_name_i(rd_name_i), .rs_name_i(rs_name_i),
    .rd_reserved_o(rd_reserved_o), .rs_reserved_o(rs_reserved_o),
    .reserve_i(reserve_i), .reserve_name_i(reserve_name_i),
    .reserve_ack_o(reserve_ack_o),
    .release_i(release_i), .release_name_i(release_name_i),
    .flush_i(flush_i), .pending_o(pending_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the DUT against whatever the stimulus queued this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      if (cur.m[4]) begin
        n_checks++;
        if (reserve_ack_o !== cur.a) begin
          n_fail++;
          $display("FAIL chk%0d.ack got %b want %b", cur.id, reserve_ack_o, cur.a);
        end
      end
      if (cur.m[3]) begin
        n_checks++;
        if (rd_reserved_o !== cur.r) begin
          n_fail++;
          $display("FAIL chk%0d.rd_reserved got %b want %b", cur.id, rd_reserved_o, cur.r);
        end
      end
      if (cur.m[2]) begin
        n_checks++;
        if (rs_reserved_o !== cur.s) begin
          n_fail++;
          $display("FAIL chk%0d.rs_reserved got %b want %b", cur.id, rs_reserved_o, cur.s);
        end
      end
      if (cur.m[1]) begin
        n_checks++;
        if (err_o !== cur.e) begin
          n_fail++;
          $display("FAIL chk%0d.err got %b want %b", cur.id, err_o, cur.e);
        end
      end
      if (cur.m[0]) begin
        n_checks++;
        if (pending_o !== cur.p) begin
          n_fail++;
          $display("FAIL chk%0d.pending got %h want %h", cur.id, pending_o, cur.p);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic rv, input int rn, input logic lv, input int ln,
                       input logic fl, input int rdn, input int rsn);
    reserve_i      = rv;
    reserve_name_i = 4'(rn);
    release_i      = lv;
    release_name_i = 4'(ln);
    flush_i        = fl;
    rd_name_i      = 4'(rdn);
    rs_name_i      = 4'(rsn);
  endtask

  task automatic expect_out(input int id, input logic [4:0] m, input logic a,
                            input logic r, input logic s, input logic e,
                            input logic [15:0] p);
    exp_t x;
    x.id = 8'(id); x.m = m; x.a = a; x.r = r; x.s = s; x.e = e; x.p = p;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 0);
    tick();
    expect_out(1, 5'b01111, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    rst = 1'b1;

    // single reservation of r3
    drive(1'b1, 3, 1'b0, 0, 1'b0, 3, 0);
    expect_out(2, 5'b11001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 3, 0);
    expect_out(3, 5'b11001, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0008);
    tick();

    // fill r5 to MAX, refuse the fourth, drain it
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5, 1'b0, 0, 1'b0, 5, 0);
      expect_out(4, 5'b10001, 1'b1, 1'b0, 1'b0, 1'b0, (i == 0) ? 16'h0008 : 16'h0028);
      tick();
    end
    drive(1'b1, 5, 1'b0, 0, 1'b0, 5, 0);
    expect_out(5, 5'b11001, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0028);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, 1'b1, 5, 1'b0, 5, 0);
      expect_out(6, 5'b01011, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0028);
      tick();
    end
    drive(1'b0, 0, 1'b0, 0, 1'b0, 5, 0);
    expect_out(7, 5'b01011, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0008);
    tick();

    // r2 full, reserve+release same register
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2, 1'b0, 0, 1'b0, 2, 0);
      expect_out(8, 5'b10000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      tick();
    end
    drive(1'b1, 2, 1'b1, 2, 1'b0, 2, 0);
    expect_out(9, 5'b11011, 1'b1, 1'b1, 1'b0, 1'b0, 16'h000C);
    tick();
    drive(1'b1, 2, 1'b0, 0, 1'b0, 2, 0);
    expect_out(10, 5'b11011, 1'b0, 1'b1, 1'b0, 1'b0, 16'h000C);
    tick();
    drive(1'b1, 2, 1'b0, 0, 1'b1, 2, 0);
    expect_out(11, 5'b10001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000C);
    tick();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 2, 0);
    expect_out(12, 5'b01011, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();

    // reserve+release of an empty register: stays 0, no error
    drive(1'b1, 9, 1'b1, 9, 1'b0, 9, 0);
    expect_out(13, 5'b10011, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 9, 0);
    expect_out(14, 5'b01011, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();

    // flush overrides reserve and release
    drive(1'b1, 1, 1'b0, 0, 1'b0, 1, 4); tick();
    drive(1'b1, 1, 1'b0, 0, 1'b0, 1, 4); tick();
    drive(1'b1, 4, 1'b0, 0, 1'b0, 1, 4); tick();
    drive(1'b1, 1, 1'b1, 4, 1'b1, 1, 4);
    expect_out(15, 5'b11101, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0012);
    tick();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 1, 4);
    expect_out(16, 5'b01111, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();

    // reserve and release to different registers together
    drive(1'b1, 10, 1'b0, 0, 1'b0, 10, 11); tick();
    drive(1'b1, 11, 1'b1, 10, 1'b0, 10, 11);
    expect_out(17, 5'b11101, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0400);
    tick();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 10, 11);
    expect_out(18, 5'b01111, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0800);
    tick();

    // underflow on r7 sets sticky error, flush keeps it
    drive(1'b0, 0, 1'b1, 7, 1'b0, 0, 7);
    expect_out(19, 5'b00111, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0800);
    tick();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 7);
    expect_out(20, 5'b00111, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0800);
    tick();
    drive(1'b0, 0, 1'b1, 7, 1'b1, 0, 7);
    expect_out(21, 5'b00010, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 7);
    expect_out(22, 5'b00011, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick();

    // async reset mid-operation
    drive(1'b1, 6, 1'b0, 0, 1'b0, 0, 6); tick();
    drive(1'b1, 6, 1'b0, 0, 1'b0, 0, 6); tick();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 6);
    expect_out(23, 5'b00111, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040);
    tick();
    rst = 1'b0;
    expect_out(24, 5'b00111, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    drive(1'b1, 6, 1'b0, 0, 1'b0, 0, 6);
    expect_out(25, 5'b00111, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    rst = 1'b1;
    expect_out(26, 5'b10111, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 6);
    expect_out(27, 5'b00111, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040);
    tick();
    tick();
    tick();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
